cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Parametrised common data bus. Collects results from NUM_SRC execution units
//  (ALU, branch ALU, load, store, ...) through per-source FIFOs. Grants one
//  result per cycle round-robin and drives it from registers onto the bus.
//  The bus is broadcast to the reservation stations, the PC unit and the ROB.
//  Adds buffering, back-pressure, fairness and flush over the single-source bus.
// PARAMETERS
//  NUM_SRC     4        number of producer channels (>=2)
//  DATA_W      32       result width
//  TAG_W       5        rename tag width (ROB entry + lock encoding)
//  ROB_W       4        ROB entry index width (ROB_W <= TAG_W)
//  FIFO_DEPTH  2        entries per source FIFO, power of 2, >=2
//  NO_TAG      {TAG_W{1'b1}}  tag value meaning "no lock / no destination"
// PORTS
//  clk         in   1                 clock, rising edge
//  rst_n       in   1                 asynchronous reset, active-low
//  flush       in   1                 synchronous squash (branch mispredict)
//  src_valid   in   NUM_SRC           per-source result valid
//  src_ready   out  NUM_SRC           per-source FIFO can accept
//  src_tag     in   NUM_SRC*TAG_W     per-source tag, source i at [i*TAG_W +: TAG_W]
//  src_data    in   NUM_SRC*DATA_W    per-source result, source i at [i*DATA_W +: DATA_W]
//  cdb_valid   out  1                 bus carries a result this cycle
//  cdb_tag     out  TAG_W             broadcast tag (NO_TAG when idle)
//  cdb_data    out  DATA_W            broadcast value (0 when idle)
//  cdb_src     out  $clog2(NUM_SRC)   index of the granted source
//  rob_write   out  1                 equals cdb_valid
//  rob_entry   out  ROB_W             cdb_tag[ROB_W-1:0]
// BEHAVIOUR
//  - Reset (rst_n=0, async): all FIFOs empty and rr_ptr=0.
//    Outputs: cdb_valid=0, cdb_tag=NO_TAG, cdb_data=0, cdb_src=0, rob_write=0.
//    src_ready is all-ones immediately. Reset mid-stream discards all buffered results.
//  - src_ready[i] = !full[i]. It depends only on registered state; no combinational path from src_valid.
//  - Push: src_valid[i] & src_ready[i] at a rising edge writes {tag,data} to FIFO i.
//    A push whose src_tag == NO_TAG is accepted but not stored (dropped).
//  - Arbitration (combinational on FIFO state): scan rr_ptr, rr_ptr+1, ...
//    mod NUM_SRC. The first non-empty FIFO wins.
//  - On each edge with a winner w:
//    - Pop the head of FIFO w into cdb_* registers, with cdb_valid=1 and cdb_src=w.
//    - rr_ptr <= (w+1) mod NUM_SRC.
//  - On each edge with no winner: cdb_valid=0, cdb_tag=NO_TAG, cdb_data=0.
//    rr_ptr and cdb_src hold.
//  - Latency: a result presented in cycle c appears on the bus in cycle c+2 at the earliest.
//    Each granted result is on the bus for exactly one cycle.
//  - Push and pop on the same FIFO in one edge are both performed; occupancy is unchanged.
//  - Pointer arithmetic wraps mod FIFO_DEPTH. Occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
//  - Ordering: FIFO order is kept within a source. No ordering holds across sources.
//  - flush=1 at an edge takes priority over push and pop:
//    - All FIFOs are emptied; same-cycle pushes are discarded.
//    - cdb_valid=0 and cdb_tag=NO_TAG in the next cycle. rr_ptr holds.
//    - A result already on the bus during the flush cycle is not retracted.
//  - Throughput: exactly 1 result per cycle while any FIFO is non-empty.
//    Source starvation is bounded by NUM_SRC-1 cycles.
// TESTING
//  1 Reset: drive rst_n low mid-stream between edges.
//    -> Outputs reach reset values immediately; src_ready=4'b1111; no later bus activity.
//  2 Single: src0 tag=3, data=32'h1234 in cycle 0.
//    -> Cycle 2: cdb_valid=1, tag=3, data=32'h1234, rob_entry=3, cdb_src=0. Cycle 3: cdb_valid=0.
//  3 Contention: all 4 sources valid in cycle 0 with tags 1,2,3,4 and rr_ptr=0.
//    -> Tags 1,2,3,4 on the bus in cycles 2,3,4,5.
//  4 Fairness/full: all sources valid every cycle, sequential tags per source.
//    -> src_ready drops once FIFO_DEPTH entries are buffered.
//    -> Grants rotate 0,1,2,3. No lost or reordered tags per source; bus valid every cycle.
//  5 Flush: 3 results buffered, flush in cycle k while src1 pushes tag 7.
//    -> Cycle k+1: cdb_valid=0. Tag 7 and the buffered results never appear.
//  6 NO_TAG: src2 pushes tag=NO_TAG (31), data=5.
//    -> src_ready[2] stays 1; no bus cycle is produced.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Bundle of per-source result channels and the broadcast common data bus.
// The arbiter takes the slave side; producers and bus consumers see the master side.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned ROB_W   = 4
);
    localparam int unsigned SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;

    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [SRC_W-1:0]          cdb_src;
    logic                      rob_write;
    logic [ROB_W-1:0]          rob_entry;

    modport master (
        output src_valid,
        output src_tag,
        output src_data,
        input  src_ready,
        input  cdb_valid,
        input  cdb_tag,
        input  cdb_data,
        input  cdb_src,
        input  rob_write,
        input  rob_entry
    );

    modport slave (
        input  src_valid,
        input  src_tag,
        input  src_data,
        output src_ready,
        output cdb_valid,
        output cdb_tag,
        output cdb_data,
        output cdb_src,
        output rob_write,
        output rob_entry
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus: per-source result FIFOs, round-robin grant of one result per cycle,
// registered broadcast to reservation stations, PC unit and ROB, with flush.
module cdb_arbiter #(
    parameter int unsigned       NUM_SRC    = 4,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       TAG_W      = 5,
    parameter int unsigned       ROB_W      = 4,
    parameter int unsigned       FIFO_DEPTH = 2,
    parameter logic [TAG_W-1:0]  NO_TAG     = {TAG_W{1'b1}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // FIFO storage and bookkeeping
    logic [TAG_W-1:0]  tag_mem  [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [NUM_SRC][FIFO_DEPTH];

    logic [NUM_SRC-1:0][PTR_W-1:0] wr_ptr_q;
    logic [NUM_SRC-1:0][PTR_W-1:0] rd_ptr_q;
    logic [NUM_SRC-1:0][CNT_W-1:0] count_q;

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] not_empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;

    // Arbitration
    logic [SRC_W-1:0]  rr_q;
    logic [SRC_W-1:0]  rr_next;
    logic              grant_valid;
    logic [SRC_W-1:0]  grant_idx;
    logic [TAG_W-1:0]  head_tag;
    logic [DATA_W-1:0] head_data;

    // Bus output registers
    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [SRC_W-1:0]  cdb_src_q;

    always_comb begin
        full      = '0;
        not_empty = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            full[i]      = (count_q[i] == CNT_W'(FIFO_DEPTH));
            not_empty[i] = (count_q[i] != '0);
        end
    end

    // Ready is purely registered state so producers see no combinational loop.
    assign bus.src_ready = ~full;

    // Walk from the highest offset down so the lowest offset from rr_q wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (not_empty[(int'(rr_q) + k) % NUM_SRC]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'((int'(rr_q) + k) % NUM_SRC);
            end
        end
    end

    always_comb begin
        if (grant_idx == SRC_W'(NUM_SRC - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = grant_idx + SRC_W'(1);
        end
    end

    assign head_tag  = tag_mem[grant_idx][rd_ptr_q[grant_idx]];
    assign head_data = data_mem[grant_idx][rd_ptr_q[grant_idx]];

    // NO_TAG results are acknowledged but never stored; flush squashes everything.
    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            push[i] = bus.src_valid[i] && !full[i] && !flush &&
                      (bus.src_tag[i*TAG_W +: TAG_W] != NO_TAG);
            pop[i]  = grant_valid && (grant_idx == SRC_W'(i)) && !flush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (flush) begin
                    wr_ptr_q[i] <= '0;
                    rd_ptr_q[i] <= '0;
                    count_q[i]  <= '0;
                end else begin
                    if (push[i]) begin
                        wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                    end
                    if (pop[i]) begin
                        rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                    end
                    if (push[i] && !pop[i]) begin
                        count_q[i] <= count_q[i] + CNT_W'(1);
                    end else if (!push[i] && pop[i]) begin
                        count_q[i] <= count_q[i] - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_ptr_q[i]]  <= bus.src_tag[i*TAG_W +: TAG_W];
                data_mem[i][wr_ptr_q[i]] <= bus.src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= NO_TAG;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
            rr_q        <= '0;
        end else if (flush) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= NO_TAG;
            cdb_data_q  <= '0;
        end else if (grant_valid) begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= head_tag;
            cdb_data_q  <= head_data;
            cdb_src_q   <= grant_idx;
            rr_q        <= rr_next;
        end else begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= NO_TAG;
            cdb_data_q  <= '0;
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;
    assign bus.rob_write = cdb_valid_q;
    assign bus.rob_entry = cdb_tag_q[ROB_W-1:0];
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_cdb_arbiter;
    localparam int N      = 4;
    localparam int DW     = 32;
    localparam int TW     = 5;
    localparam int RW     = 4;
    localparam int DEPTH  = 2;
    localparam logic [TW-1:0] NO_TAG = 5'h1f;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_SRC(N), .DATA_W(DW), .TAG_W(TW), .ROB_W(RW)) bus ();

    cdb_arbiter #(
        .NUM_SRC(N), .DATA_W(DW), .TAG_W(TW), .ROB_W(RW), .FIFO_DEPTH(DEPTH), .NO_TAG(NO_TAG)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of {tag,data} per source plus a round-robin pointer.
    logic [TW+DW-1:0] mq [N][$];
    int               rr;
    logic             e_valid;
    logic [TW-1:0]    e_tag;
    logic [DW-1:0]    e_data;
    int               e_src;

    logic [TW-1:0] tb_tag  [N];
    logic [DW-1:0] tb_data [N];
    logic [N-1:0]  acc_last;
    int            seq [N];
    logic          saw_not_ready;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        rr      = 0;
        e_valid = 1'b0;
        e_tag   = NO_TAG;
        e_data  = '0;
        e_src   = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] v, input logic fl);
        int w;
        logic [TW+DW-1:0] ent;
        logic [N-1:0] acc;
        for (int i = 0; i < N; i++) acc[i] = v[i] && (mq[i].size() < DEPTH);
        acc_last = fl ? '0 : acc;
        if (fl) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            e_valid = 1'b0;
            e_tag   = NO_TAG;
            e_data  = '0;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && mq[(rr + k) % N].size() > 0) w = (rr + k) % N;
            if (w >= 0) begin
                ent     = mq[w].pop_front();
                e_valid = 1'b1;
                e_tag   = ent[TW+DW-1:DW];
                e_data  = ent[DW-1:0];
                e_src   = w;
                rr      = (w + 1) % N;
            end else begin
                e_valid = 1'b0;
                e_tag   = NO_TAG;
                e_data  = '0;
            end
            for (int i = 0; i < N; i++)
                if (acc[i] && tb_tag[i] != NO_TAG) mq[i].push_back({tb_tag[i], tb_data[i]});
        end
    endtask

    task automatic check_outputs();
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(e_valid));
        chk("cdb_tag",   64'(bus.cdb_tag),   64'(e_tag));
        chk("cdb_data",  64'(bus.cdb_data),  64'(e_data));
        chk("cdb_src",   64'(bus.cdb_src),   64'(e_src));
        chk("rob_write", 64'(bus.rob_write), 64'(e_valid));
        chk("rob_entry", 64'(bus.rob_entry), 64'(e_tag[RW-1:0]));
    endtask

    // One cycle: drive inputs, check ready, clock, update model, check registered outputs.
    task automatic step(input logic [N-1:0] v, input logic fl);
        logic [N-1:0] exp_ready;
        for (int i = 0; i < N; i++) begin
            exp_ready[i]                  = (mq[i].size() < DEPTH);
            bus.src_tag[i*TW +: TW]       = tb_tag[i];
            bus.src_data[i*DW +: DW]      = tb_data[i];
        end
        bus.src_valid = v;
        flush         = fl;
        #1;
        chk("src_ready", 64'(bus.src_ready), 64'(exp_ready));
        if (bus.src_ready != '1) saw_not_ready = 1'b1;
        @(posedge clk);
        model_edge(v, fl);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        for (int c = 0; c < 20; c++) begin
            if (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() == 0 && !e_valid) break;
            step('0, 1'b0);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.src_valid = '0;
        bus.src_tag   = '0;
        bus.src_data  = '0;
        saw_not_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            tb_tag[i]  = '0;
            tb_data[i] = '0;
            seq[i]     = 0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        chk("reset_ready", 64'(bus.src_ready), 64'hf);
        rst_n = 1'b1;

        // Contention from rr_ptr=0: tags 1..4 on bus in cycles 2..5
        for (int i = 0; i < N; i++) begin
            tb_tag[i]  = TW'(i + 1);
            tb_data[i] = 32'hA000 + DW'(i);
        end
        step(4'hf, 1'b0);
        chk("t3_idle_c1", 64'(bus.cdb_valid), 64'h0);
        for (int k = 0; k < N; k++) begin
            step('0, 1'b0);
            chk("t3_tag", 64'(bus.cdb_tag), 64'(k + 1));
            chk("t3_src", 64'(bus.cdb_src), 64'(k));
        end
        step('0, 1'b0);

        // Single result from src0
        tb_tag[0]  = 5'd3;
        tb_data[0] = 32'h1234;
        step(4'b0001, 1'b0);
        chk("t2_c1_valid", 64'(bus.cdb_valid), 64'h0);
        step('0, 1'b0);
        chk("t2_c2_valid", 64'(bus.cdb_valid), 64'h1);
        chk("t2_c2_tag",   64'(bus.cdb_tag),   64'h3);
        chk("t2_c2_data",  64'(bus.cdb_data),  64'h1234);
        chk("t2_c2_entry", 64'(bus.rob_entry), 64'h3);
        chk("t2_c2_src",   64'(bus.cdb_src),   64'h0);
        step('0, 1'b0);
        chk("t2_c3_valid", 64'(bus.cdb_valid), 64'h0);

        // Saturation: every source valid every cycle, sequential tags per source
        saw_not_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < N; i++) begin
                tb_tag[i]  = TW'(i * 6 + (seq[i] % 6));
                tb_data[i] = DW'((i << 16) | seq[i]);
            end
            step(4'hf, 1'b0);
            for (int i = 0; i < N; i++) if (acc_last[i]) seq[i]++;
            if (c >= 1) chk("t4_bus_busy", 64'(bus.cdb_valid), 64'h1);
        end
        chk("t4_ready_dropped", 64'(saw_not_ready), 64'h1);
        drain();

        // Flush with three results buffered and a same-cycle push of tag 7
        tb_tag[0] = 5'd10; tb_data[0] = 32'h10;
        tb_tag[2] = 5'd12; tb_data[2] = 32'h12;
        tb_tag[3] = 5'd13; tb_data[3] = 32'h13;
        step(4'b1101, 1'b0);
        tb_tag[1] = 5'd7; tb_data[1] = 32'h77;
        step(4'b0010, 1'b1);
        chk("t5_k1_valid", 64'(bus.cdb_valid), 64'h0);
        chk("t5_k1_tag",   64'(bus.cdb_tag),   64'(NO_TAG));
        for (int c = 0; c < 4; c++) begin
            step('0, 1'b0);
            chk("t5_quiet", 64'(bus.cdb_valid), 64'h0);
        end

        // NO_TAG push is accepted but produces no bus cycle
        tb_tag[2]  = NO_TAG;
        tb_data[2] = 32'd5;
        step(4'b0100, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(4'b0100, 1'b0);
            chk("t6_ready2", 64'(bus.src_ready[2]), 64'h1);
            chk("t6_quiet",  64'(bus.cdb_valid),    64'h0);
        end

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                tb_tag[i]  = ($urandom_range(0, 29) == 0) ? NO_TAG : TW'($urandom_range(0, 30));
                tb_data[i] = $urandom;
            end
            step(N'($urandom), $urandom_range(0, 39) == 0);
        end

        // Asynchronous reset mid-stream, between edges
        for (int i = 0; i < N; i++) begin
            tb_tag[i]  = TW'(i + 20);
            tb_data[i] = DW'(i);
        end
        step(4'hf, 1'b0);
        step(4'hf, 1'b0);
        bus.src_valid = '0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("t1_ready", 64'(bus.src_ready), 64'hf);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step('0, 1'b0);
            chk("t1_quiet", 64'(bus.cdb_valid), 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
